// File: rtl/serial_frame_arbiter.sv
// serial_frame_arbiter: round-robin sharing of one serial line, frames start/addr/len/data/stop.
// Define PARITY_EN to insert an even-parity bit over the data bits before the stop bit.
module serial_frame_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 4,
    parameter int DATA_W = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clkEn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CNT_W-1:0]   len,
    input  logic [NREQ*DATA_W-1:0]  data,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    serOut,
    output logic                    busy
);
`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, ADDR, CNT, DATA, PARITY, GAP} state_t;
    localparam state_t TAIL = PARITY;
    logic par;
`else
    typedef enum logic [2:0] {IDLE, START, ADDR, CNT, DATA, GAP} state_t;
    localparam state_t TAIL = GAP;
`endif
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, cnt_n, len_q, len_sh;
    logic [ADDR_W-1:0] rr, idx_q, addr_sh, win;
    logic [DATA_W-1:0] data_q;
    logic found, bit_n;
    // lowest requester above rr wins; otherwise wrap to the lowest requester overall
    always_comb begin
        found = |req;
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) win = ADDR_W'(i);
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i] && i > int'(rr)) win = ADDR_W'(i);
    end
    // serOut is registered: each state's bit appears on the line after its tick
    always_comb begin
        nxt = state;
        cnt_n = cnt - 1'b1;
        bit_n = 1'b1;
        case (state)
            START: begin
                bit_n = 1'b0;
                nxt = ADDR;
                cnt_n = CNT_W'(ADDR_W - 1);
            end
            ADDR: begin
                bit_n = addr_sh[ADDR_W-1];
                if (cnt == '0) begin
                    nxt = CNT;
                    cnt_n = CNT_W'(CNT_W - 1);
                end
            end
            CNT: begin
                bit_n = len_sh[CNT_W-1];
                if (cnt == '0) begin
                    nxt = (len_q != '0) ? DATA : TAIL;
                    cnt_n = len_q - 1'b1;
                end
            end
            DATA: begin
                bit_n = data_q[cnt];
                nxt = (cnt == '0) ? TAIL : DATA;
            end
`ifdef PARITY_EN
            PARITY: begin
                bit_n = par;
                nxt = GAP;
            end
`endif
            GAP: nxt = IDLE;
            default: nxt = found ? START : IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            serOut <= 1'b1;
            grant <= '0;
            done <= '0;
            busy <= 1'b0;
            rr <= ADDR_W'(NREQ - 1);
            idx_q <= '0;
            addr_sh <= '0;
            len_q <= '0;
            len_sh <= '0;
            data_q <= '0;
`ifdef PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            done <= '0;
            if (clkEn) begin
                state <= nxt;
                cnt <= cnt_n;
                serOut <= bit_n;
                if (state == IDLE && found) begin
                    grant <= NREQ'(1) << win;
                    busy <= 1'b1;
                    idx_q <= win;
                    addr_sh <= win;
                    len_q <= len[win*CNT_W +: CNT_W];
                    len_sh <= len[win*CNT_W +: CNT_W];
                    data_q <= data[win*DATA_W +: DATA_W];
`ifdef PARITY_EN
                    par <= 1'b0;
`endif
                end
                if (state == ADDR) addr_sh <= addr_sh << 1;
                if (state == CNT) len_sh <= len_sh << 1;
`ifdef PARITY_EN
                if (state == DATA) par <= par ^ bit_n;
`endif
                if (state == GAP) begin
                    done <= NREQ'(1) << idx_q;
                    rr <= idx_q;
                    grant <= '0;
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_arbiter.sv
// tb_serial_frame_arbiter: directed checks of framing, round-robin, clkEn pacing and reset.
module tb_serial_frame_arbiter;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    logic clk = 1'b0, rst = 1'b1, clkEn = 1'b1;
    logic [3:0] req = '0;
    logic [15:0] len = '0;
    logic [59:0] data = '0;
    logic [3:0] grant, done;
    logic serOut, busy;
    int total = 0, bad = 0;

    serial_frame_arbiter dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .req(req), .len(len), .data(data),
        .grant(grant), .done(done), .serOut(serOut), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int nb(input int l);
        return 8 + l + P;
    endfunction

    // expected line bits, MSB first, in the low nb(l) bits
    function automatic logic [31:0] frm(input int a, input int l, input logic [14:0] d);
        logic [31:0] v;
        logic p;
        v = '0;
        p = 1'b0;
        v = {v[30:0], 1'b0};
        for (int i = 1; i >= 0; i--) v = {v[30:0], a[i]};
        for (int i = 3; i >= 0; i--) v = {v[30:0], l[i]};
        for (int i = l - 1; i >= 0; i--) begin
            v = {v[30:0], d[i]};
            p = p ^ d[i];
        end
        if (P == 1) v = {v[30:0], p};
        v = {v[30:0], 1'b1};
        return v;
    endfunction

    task automatic run_frame(input string tag, input logic [3:0] g, input logic [31:0] bits,
                             input int n, input int mod_at);
        tick();
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".idle"}, serOut, 1);
        for (int k = 0; k < n; k++) begin
            if (k == mod_at) begin
                req[2] = 1'b0;
                len[11:8] = 4'd1;
                data[44:30] = '0;
            end
            tick();
            chk($sformatf("%s.ser%0d", tag, k), serOut, bits[n-1-k]);
            if (k == n - 1) begin
                chk({tag, ".done"}, done, g);
                chk({tag, ".grant_clr"}, grant, 0);
                chk({tag, ".busy_clr"}, busy, 0);
            end else
                chk($sformatf("%s.nodone%0d", tag, k), done, 0);
        end
    endtask

    initial begin
        logic [31:0] b;
        tick();
        chk("rst.grant", grant, 0);
        chk("rst.done", done, 0);
        chk("rst.ser", serOut, 1);
        chk("rst.busy", busy, 0);
        rst = 1'b0;

        // single frame, hand-derived line bits
        req = 4'b0010;
        len[7:4] = 4'd3;
        data[29:15] = 15'b101;
        b = (P == 1) ? 32'b001001110101 : 32'b00100111011;
        run_frame("t1", 4'b0010, b, nb(3), -1);
        req = '0;
        tick();
        chk("t1.done_once", done, 0);
        chk("t1.busy_after", busy, 0);

        // round-robin, all requesting
        do_reset();
        req = 4'b1111;
        len = 16'h1111;
        data = {15'd1, 15'd1, 15'd1, 15'd1};
        run_frame("t2a", 4'b0001, frm(0, 1, 15'd1), nb(1), -1);
        run_frame("t2b", 4'b0010, frm(1, 1, 15'd1), nb(1), -1);
        run_frame("t2c", 4'b0100, frm(2, 1, 15'd1), nb(1), -1);
        run_frame("t2d", 4'b1000, frm(3, 1, 15'd1), nb(1), -1);
        run_frame("t2e", 4'b0001, frm(0, 1, 15'd1), nb(1), -1);
        req = '0;
        tick();
        chk("t2.idle_grant", grant, 0);
        chk("t2.idle_ser", serOut, 1);

        // zero-length frame
        do_reset();
        req = 4'b0001;
        len = '0;
        data = '0;
        b = (P == 1) ? 32'b000000001 : 32'b00000001;
        run_frame("t3", 4'b0001, b, nb(0), -1);
        req = '0;
        tick();

        // inputs changed mid-DATA are ignored
        req = 4'b0100;
        len[11:8] = 4'd5;
        data[44:30] = 15'h1F;
        run_frame("t4", 4'b0100, frm(2, 5, 15'h1F), nb(5), 9);
        tick();
        chk("t4.no_regrant", grant, 0);

        // clkEn every 4 clocks
        do_reset();
        req = 4'b0010;
        len[7:4] = 4'd3;
        data[29:15] = 15'b101;
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        chk("t5.grant", grant, 4'b0010);
        req = '0;
        repeat (3) tick();
        b = frm(1, 3, 15'b101);
        for (int k = 0; k < nb(3); k++) begin
            clkEn = 1'b1;
            tick();
            clkEn = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (s > 0) tick();
                chk($sformatf("t5.ser%0d_%0d", k, s), serOut, b[nb(3)-1-k]);
                chk($sformatf("t5.done%0d_%0d", k, s), done,
                    (k == nb(3) - 1 && s == 0) ? 4'b0010 : 4'b0000);
            end
        end
        clkEn = 1'b1;

        // reset mid-DATA
        do_reset();
        req = 4'b0100;
        len[11:8] = 4'd5;
        data[44:30] = '0;
        tick();
        chk("t6.grant", grant, 4'b0100);
        repeat (9) tick();
        chk("t6.in_data", serOut, 0);
        chk("t6.busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6.rst_ser", serOut, 1);
        chk("t6.rst_grant", grant, 0);
        chk("t6.rst_busy", busy, 0);
        chk("t6.rst_done", done, 0);
        tick();
        chk("t6.rst_done2", done, 0);
        rst = 1'b0;
        req = 4'b1000;
        len[15:12] = 4'd2;
        data[59:45] = 15'b10;
        run_frame("t6b", 4'b1000, frm(3, 2, 15'b10), nb(2), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
